// File: rtl/leaf_router.sv
// rtl/leaf_router.sv - first-hop NoC switch: 4 local NIs plus one uplink, buffered inputs,
// header routing, per-output round-robin arbitration and registered outputs.
module leaf_router #(
  parameter int MY_GROUP = 7,
  parameter int DATA_W   = 16,
  parameter int HEADER_W = 6,
  parameter int IN_DEPTH = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DATA_W-1:0] loc_data_in,
  input  logic [3:0]          loc_valid_in,
  output logic [3:0]          loc_ready_out,
  output logic [4*DATA_W-1:0] loc_data_out,
  output logic [3:0]          loc_valid_out,
  input  logic [DATA_W-1:0]   up_data_in,
  input  logic                up_valid_in,
  output logic                up_ready_out,
  output logic [DATA_W-1:0]   up_data_out,
  output logic                up_valid_out,
  input  logic                up_ready_in,
  output logic [CNT_W-1:0]    drop_count,
  output logic [4:0]          overflow
);

  localparam int N_IN   = 5;
  localparam int UP     = 4;
  localparam int PTR_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int CNT_FW = $clog2(IN_DEPTH + 1);
  localparam int GRP_W  = HEADER_W - 2;
  localparam logic [GRP_W-1:0] GROUP = GRP_W'(MY_GROUP);

  logic [DATA_W-1:0]   mem [N_IN][IN_DEPTH];
  logic [PTR_W-1:0]    wr_ptr [N_IN];
  logic [PTR_W-1:0]    rd_ptr [N_IN];
  logic [CNT_FW-1:0]   count [N_IN];
  logic [DATA_W-1:0]   data_in [N_IN];
  logic [DATA_W-1:0]   head [N_IN];
  logic [HEADER_W-1:0] hdr [N_IN];
  logic [N_IN-1:0]     req [N_IN];
  logic [2:0]          gnt_idx [N_IN];
  logic [2:0]          rr_ptr [N_IN];
  logic [N_IN-1:0]     valid_in, ready, write_ok, ovf_hit, drop_head, pop, gnt_any;
  logic                up_free;
  logic [3:0]          drop_sum;
  logic [CNT_W+4:0]    drop_ext;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == IN_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [2:0] rr_add(input logic [2:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_IN) s = s - N_IN;
    return 3'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) data_in[i] = loc_data_in[i*DATA_W +: DATA_W];
    data_in[UP] = up_data_in;
    valid_in    = {up_valid_in, loc_valid_in};
  end

  // Credit threshold leaves room for the flit already in flight on the one-cycle credit loop.
  always_comb begin
    ready    = '0;
    write_ok = '0;
    ovf_hit  = '0;
    for (int n = 0; n < N_IN; n++) begin
      ready[n]    = (int'(count[n]) + int'(valid_in[n])) <= IN_DEPTH - 2;
      write_ok[n] = valid_in[n] && (int'(count[n]) != IN_DEPTH);
      ovf_hit[n]  = valid_in[n] && (int'(count[n]) == IN_DEPTH);
      head[n]     = mem[n][rd_ptr[n]];
      hdr[n]      = head[n][DATA_W-1 -: HEADER_W];
    end
  end

  assign loc_ready_out = ready[3:0];
  assign up_ready_out  = ready[UP];

  always_comb begin
    drop_head = '0;
    for (int o = 0; o < N_IN; o++) req[o] = '0;
    for (int n = 0; n < N_IN; n++) begin
      if (count[n] != '0) begin
        if (hdr[n] == '0) drop_head[n] = 1'b1;
        else if (hdr[n][HEADER_W-1:2] == GROUP) req[int'(hdr[n][1:0])][n] = 1'b1;
        else if (n == UP) drop_head[n] = 1'b1;
        else req[UP][n] = 1'b1;
      end
    end
  end

  assign up_free = !up_valid_out || up_ready_in;

  always_comb begin
    gnt_any = '0;
    pop     = drop_head;
    for (int o = 0; o < N_IN; o++) begin
      gnt_idx[o] = '0;
      if (o != UP || up_free) begin
        for (int k = 0; k < N_IN; k++) begin
          if (!gnt_any[o] && req[o][rr_add(rr_ptr[o], k)]) begin
            gnt_any[o] = 1'b1;
            gnt_idx[o] = rr_add(rr_ptr[o], k);
          end
        end
      end
      if (gnt_any[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    drop_sum = '0;
    for (int n = 0; n < N_IN; n++)
      drop_sum = drop_sum + {3'b000, ovf_hit[n]} + {3'b000, drop_head[n]};
    drop_ext = (CNT_W+5)'(drop_count) + (CNT_W+5)'(drop_sum);
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < N_IN; n++)
      if (write_ok[n]) mem[n][wr_ptr[n]] <= data_in[n];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < N_IN; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        count[n]  <= '0;
        rr_ptr[n] <= '0;
      end
      overflow   <= '0;
      drop_count <= '0;
    end else begin
      for (int n = 0; n < N_IN; n++) begin
        if (write_ok[n]) wr_ptr[n] <= ptr_inc(wr_ptr[n]);
        if (pop[n]) rd_ptr[n] <= ptr_inc(rd_ptr[n]);
        count[n] <= count[n] + CNT_FW'(write_ok[n]) - CNT_FW'(pop[n]);
        if (gnt_any[n]) rr_ptr[n] <= rr_add(gnt_idx[n], 1);
      end
      overflow <= overflow | ovf_hit;
      if (drop_ext > (CNT_W+5)'({CNT_W{1'b1}})) drop_count <= {CNT_W{1'b1}};
      else drop_count <= drop_ext[CNT_W-1:0];
    end
  end

  // Local outputs pulse for one cycle; the uplink register holds until the group router accepts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loc_data_out  <= '0;
      loc_valid_out <= '0;
      up_data_out   <= '0;
      up_valid_out  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        loc_valid_out[i] <= gnt_any[i];
        if (gnt_any[i]) loc_data_out[i*DATA_W +: DATA_W] <= head[gnt_idx[i]];
      end
      if (gnt_any[UP]) begin
        up_data_out  <= head[gnt_idx[UP]];
        up_valid_out <= 1'b1;
      end else if (up_ready_in) begin
        up_valid_out <= 1'b0;
      end
    end
  end

endmodule
